// File: rtl/egg_countdown_timer.sv
// Countdown engine for the egg timer. It captures MM:SS BCD digits from the set/start FSM
// and counts down at one second per clock. On expiry it pulses cook_time, then holds alarm.
module egg_countdown_timer #(
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic       pulse_1Hz,
    input  logic       reset,
    input  logic       enable_timer_cooktime,
    input  logic [3:0] load_second_ones,
    input  logic [3:0] load_second_tens,
    input  logic [3:0] load_minute_ones,
    input  logic [3:0] load_minute_tens,
    input  logic       pause,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       cook_time,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] ALARM_LOAD = 4'(ALARM_SECS - 1);

    state_t     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] alarm_cnt_q, alarm_cnt_d;
    logic       en_d_q;
    logic       running_q, cook_time_q, alarm_q;
    logic       cook_time_d;
    logic       start;
    logic       all_zero;

    function automatic logic [3:0] clamp_ones(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] clamp_tens(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    assign start    = en_d_q & ~enable_timer_cooktime;
    assign all_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                      (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        alarm_cnt_d = alarm_cnt_q;
        cook_time_d = 1'b0;

        if (enable_timer_cooktime) begin
            state_d    = IDLE;
            sec_ones_d = clamp_ones(load_second_ones);
            sec_tens_d = clamp_tens(load_second_tens);
            min_ones_d = clamp_ones(load_minute_ones);
            min_tens_d = clamp_tens(load_minute_tens);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (all_zero) begin
                        state_d     = ALARM;
                        cook_time_d = 1'b1;
                        alarm_cnt_d = ALARM_LOAD;
                    end else if (sec_ones_q != 4'd0) begin
                        sec_ones_d = sec_ones_q - 4'd1;
                    end else begin
                        // BCD borrow chain; the zero check above keeps min_tens from wrapping.
                        sec_ones_d = 4'd9;
                        if (sec_tens_q != 4'd0) begin
                            sec_tens_d = sec_tens_q - 4'd1;
                        end else begin
                            sec_tens_d = 4'd5;
                            if (min_ones_q != 4'd0) begin
                                min_ones_d = min_ones_q - 4'd1;
                            end else begin
                                min_ones_d = 4'd9;
                                min_tens_d = min_tens_q - 4'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) state_d = RUN;
                end
                ALARM: begin
                    if (alarm_cnt_q == 4'd0) state_d = IDLE;
                    else                     alarm_cnt_d = alarm_cnt_q - 4'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pulse_1Hz) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (reset) begin
            state_q     <= IDLE;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 4'd0;
            alarm_cnt_q <= 4'd0;
            en_d_q      <= 1'b0;
            running_q   <= 1'b0;
            cook_time_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            alarm_cnt_q <= alarm_cnt_d;
            en_d_q      <= enable_timer_cooktime;
            running_q   <= (state_d == RUN);
            cook_time_q <= cook_time_d;
            alarm_q     <= (state_d == ALARM);
        end
    end

    assign sec_ones  = sec_ones_q;
    assign sec_tens  = sec_tens_q;
    assign min_ones  = min_ones_q;
    assign min_tens  = min_tens_q;
    assign running   = running_q;
    assign cook_time = cook_time_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_egg_countdown_timer.sv
// Scoreboard bench for egg_countdown_timer. Stimulus queues the expected outputs for each
// cycle, and a negedge monitor pops each entry and compares it with the DUT.
module tb_egg_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_timer_cooktime = 1'b0;
    logic [3:0] load_second_ones = 4'd0;
    logic [3:0] load_second_tens = 4'd0;
    logic [3:0] load_minute_ones = 4'd0;
    logic [3:0] load_minute_tens = 4'd0;
    logic       pause = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, cook_time, alarm;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    egg_countdown_timer #(.ALARM_SECS(5)) dut (
        .pulse_1Hz            (clk),
        .reset                (reset),
        .enable_timer_cooktime(enable_timer_cooktime),
        .load_second_ones     (load_second_ones),
        .load_second_tens     (load_second_tens),
        .load_minute_ones     (load_minute_ones),
        .load_minute_tens     (load_minute_tens),
        .pause                (pause),
        .sec_ones             (sec_ones),
        .sec_tens             (sec_tens),
        .min_ones             (min_ones),
        .min_tens             (min_tens),
        .running              (running),
        .cook_time            (cook_time),
        .alarm                (alarm)
    );

    // Seconds count -> MM:SS BCD digits {min_tens, min_ones, sec_tens, sec_ones}.
    function automatic logic [15:0] mmss(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic en, input logic p, input logic [15:0] ld,
                       input logic [15:0] exp_dig, input logic exp_run, input logic exp_cook,
                       input logic exp_alarm, input string nm);
        reset = rst;
        enable_timer_cooktime = en;
        pause = p;
        {load_minute_tens, load_minute_ones, load_second_tens, load_second_ones} = ld;
        @(posedge clk);
        exp_q.push_back({exp_dig, exp_run, exp_cook, exp_alarm});
        name_q.push_back(nm);
        #1;
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    initial begin
        logic [18:0] e;
        logic [18:0] got;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {min_tens, min_ones, sec_tens, sec_ones, running, cook_time, alarm};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got digits=%h run/cook/alarm=%b expected digits=%h run/cook/alarm=%b",
                             nm, got[18:3], got[2:0], e[18:3], e[2:0]);
                end
            end
        end
    end

    initial begin
        logic [15:0] rnd_ld;

        // 1. Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            rnd_ld = 16'($urandom);
            cyc(1'b1, 1'($urandom), 1'($urandom), rnd_ld, 16'h0000, 1'b0, 1'b0, 1'b0, "reset");
        end

        // 2. Load 01:02, full countdown, cook_time pulse, 5-cycle alarm.
        cyc(1'b0, 1'b1, 1'b0, 16'h0102, 16'h0102, 1'b0, 1'b0, 1'b0, "t2_load");
        cyc(1'b0, 1'b0, 1'b0, 16'h0102, 16'h0102, 1'b1, 1'b0, 1'b0, "t2_start");
        for (int k = 1; k <= 62; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'h0102, mmss(62 - k), 1'b1, 1'b0, 1'b0, "t2_count");
        cyc(1'b0, 1'b0, 1'b0, 16'h0102, 16'h0000, 1'b0, 1'b1, 1'b1, "t2_cook");
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'h0102, 16'h0000, 1'b0, 1'b0, 1'b1, "t2_alarm");
        cyc(1'b0, 1'b0, 1'b0, 16'h0102, 16'h0000, 1'b0, 1'b0, 1'b0, "t2_idle");

        // 3. Load 00:10, pause after three decrements for four cycles.
        cyc(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0, "t3_load");
        cyc(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, "t3_start");
        for (int k = 1; k <= 3; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'h0010, mmss(10 - k), 1'b1, 1'b0, 1'b0, "t3_count");
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0007, 1'b0, 1'b0, 1'b0, "t3_pause");
        cyc(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0007, 1'b1, 1'b0, 1'b0, "t3_resume");
        cyc(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0006, 1'b1, 1'b0, 1'b0, "t3_after");

        // 4. Load 00:00 from RUN; immediate cook_time; pause ignored in alarm.
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "t4_load");
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "t4_start");
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, "t4_cook");
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, "t4_alarm");
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "t4_idle");

        // 5. Enable raised mid-RUN at 00:40 with load 12:34.
        cyc(1'b0, 1'b1, 1'b0, 16'h0045, 16'h0045, 1'b0, 1'b0, 1'b0, "t5_load");
        cyc(1'b0, 1'b0, 1'b0, 16'h0045, 16'h0045, 1'b1, 1'b0, 1'b0, "t5_start");
        for (int k = 1; k <= 5; k++)
            cyc(1'b0, 1'b0, 1'b0, 16'h0045, mmss(45 - k), 1'b1, 1'b0, 1'b0, "t5_count");
        cyc(1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, "t5_reload");

        // 6. Clamp 7F:AB -> 59:59, then 10:00 -> 09:59 borrow.
        cyc(1'b0, 1'b1, 1'b0, 16'h7FAB, 16'h5959, 1'b0, 1'b0, 1'b0, "t6_clamp");
        cyc(1'b0, 1'b0, 1'b0, 16'h7FAB, 16'h5959, 1'b1, 1'b0, 1'b0, "t6_start");
        cyc(1'b0, 1'b0, 1'b0, 16'h7FAB, 16'h5958, 1'b1, 1'b0, 1'b0, "t6_dec");
        cyc(1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, "t6_load10");
        cyc(1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b1, 1'b0, 1'b0, "t6_start10");
        cyc(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0959, 1'b1, 1'b0, 1'b0, "t6_borrow");

        // Reset overrides enable; no spurious start after reset.
        cyc(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_over_en");
        cyc(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, "no_start_after_rst");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
